// File: rtl/vector_lane_fu_pkg.sv
// Shared execution-side types: vector register geometry, opcodes and the
// register-file control request carried by every lane.
package vector_lane_fu_pkg;

  localparam int unsigned VECTOR_REG_WIDTH  = 32;
  localparam int unsigned NUM_OF_VECTOR_REG = 32;
  localparam int unsigned ADDR_FIELD_WIDTH  = 8;
  localparam int unsigned VREG_IDX_W        = $clog2(NUM_OF_VECTOR_REG);

  typedef logic [VREG_IDX_W-1:0] v_register_t;

  typedef enum logic [2:0] {
    SADD = 3'd0,
    SSUB = 3'd1,
    SMUL = 3'd2,
    SDIV = 3'd3
  } function_opcode_t;

  typedef enum logic {
    READ_REQ  = 1'b0,
    WRITE_REQ = 1'b1
  } access_type_t;

  typedef enum logic {
    NON_STRIDE = 1'b0,
    STRIDE     = 1'b1
  } stride_type_t;

  typedef struct packed {
    logic                         vld;
    access_type_t                 access_type;
    logic [ADDR_FIELD_WIDTH-1:0]  access_length;
    stride_type_t                 stride_type;
    v_register_t                  vec_reg_ptr;
    logic [ADDR_FIELD_WIDTH-1:0]  addr;
    logic [VECTOR_REG_WIDTH-1:0]  data;
  } cntrl_req_t;

  // True when a lane can execute the opcode; SDIV only with a divider present.
  function automatic logic op_supported(input function_opcode_t op, input logic div_en);
    case (op)
      SADD, SSUB, SMUL: op_supported = 1'b1;
      SDIV:             op_supported = div_en;
      default:          op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/vector_lane_fu_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// Only instantiated when LANE_DIV_EN is defined. A zero divisor naturally
// yields an all-ones quotient because every trial subtraction succeeds.
module lane_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient_c,
  output logic             done_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   rem_sh;
  logic             fits;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  // One restoring step: shift in the next dividend bit and trial-subtract.
  always_comb begin
    rem_sh     = {rem, quo[WIDTH-1]};
    fits       = (rem_sh >= {1'b0, dvs});
    rem_nxt    = fits ? WIDTH'(rem_sh - {1'b0, dvs}) : rem_sh[WIDTH-1:0];
    quo_nxt    = {quo[WIDTH-2:0], fits};
    quotient_c = quo_nxt;
    done_c     = (cnt == CNT_W'(1));
  end

  // Load on start, then iterate WIDTH times.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      cnt <= '0;
    end else if (start) begin
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
      cnt <= CNT_W'(WIDTH);
    end else if (cnt != '0) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/vector_lane_fu.sv
// One vector functional-unit lane: accepts an element op, computes it and
// writes the result back through a register-file write request.
// Optional feature macro: LANE_DIV_EN (adds the iterative SDIV divider).
module vector_lane_fu
  import vector_lane_fu_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 3,
  parameter int unsigned DIV_WIDTH   = VECTOR_REG_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        vld,
  input  logic [VECTOR_REG_WIDTH-1:0] data0,
  input  logic [VECTOR_REG_WIDTH-1:0] data1,
  input  logic [VREG_IDX_W-1:0]       vec_reg_in,
  input  logic [ADDR_FIELD_WIDTH-1:0] vec_addr,
  input  function_opcode_t            functional_opcode,
  output logic                        busy,
  output cntrl_req_t                  wr_req,
  input  logic                        wr_req_grant,
  output logic                        illegal_op
);

  typedef enum logic [1:0] {IDLE, EXEC, WRITE} lane_state_t;

  localparam int unsigned CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  if (MUL_LATENCY < 1) begin : g_bad_mul_latency
    $error("MUL_LATENCY must be at least 1");
  end
  if (DIV_WIDTH < 2) begin : g_bad_div_width
    $error("DIV_WIDTH must be at least 2");
  end

  lane_state_t                 state;
  logic [VECTOR_REG_WIDTH-1:0] op_a;
  logic [VECTOR_REG_WIDTH-1:0] op_b;
  function_opcode_t            opcode;
  v_register_t                 dest;
  logic [ADDR_FIELD_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]            cnt;

  logic [VECTOR_REG_WIDTH-1:0] result_c;
  logic                        exec_done_c;

`ifdef LANE_DIV_EN
  localparam logic DIV_EN = 1'b1;

  logic                 div_start_c;
  logic [DIV_WIDTH-1:0] div_quotient_c;
  logic                 div_done_c;

  assign div_start_c = vld && !busy && (functional_opcode == SDIV);

  lane_divider #(.WIDTH(DIV_WIDTH)) u_div (
    .clk        (clk),
    .rst_n      (reset),
    .start      (div_start_c),
    .dividend   (DIV_WIDTH'(data0)),
    .divisor    (DIV_WIDTH'(data1)),
    .quotient_c (div_quotient_c),
    .done_c     (div_done_c)
  );
`else
  localparam logic DIV_EN = 1'b0;
`endif

  // Result select and end-of-execution detect for the latched opcode.
  always_comb begin
    result_c    = '0;
    exec_done_c = (cnt == '0);
    case (opcode)
      SADD: result_c = op_a + op_b;
      SSUB: result_c = op_a - op_b;
      SMUL: result_c = VECTOR_REG_WIDTH'(op_a * op_b);
`ifdef LANE_DIV_EN
      SDIV: begin
        result_c    = VECTOR_REG_WIDTH'(div_quotient_c);
        exec_done_c = div_done_c;
      end
`endif
      default: result_c = '0;
    endcase
  end

  // Lane FSM: capture in IDLE, compute in EXEC, hold the write request until granted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      illegal_op <= 1'b0;
      wr_req     <= '0;
      op_a       <= '0;
      op_b       <= '0;
      opcode     <= SADD;
      dest       <= '0;
      addr_q     <= '0;
      cnt        <= '0;
    end else begin
      illegal_op <= 1'b0;
      case (state)
        IDLE: begin
          if (vld && !busy) begin
            op_a       <= data0;
            op_b       <= data1;
            opcode     <= functional_opcode;
            dest       <= v_register_t'(vec_reg_in);
            addr_q     <= vec_addr;
            cnt        <= (functional_opcode == SMUL) ? CNT_W'(MUL_LATENCY - 1) : '0;
            illegal_op <= !op_supported(functional_opcode, DIV_EN);
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (exec_done_c) begin
            wr_req.vld           <= 1'b1;
            wr_req.access_type   <= WRITE_REQ;
            wr_req.access_length <= '0;
            wr_req.stride_type   <= NON_STRIDE;
            wr_req.vec_reg_ptr   <= dest;
            wr_req.addr          <= addr_q;
            wr_req.data          <= result_c;
            state                <= WRITE;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WRITE: begin
          if (wr_req_grant) begin
            wr_req <= '0;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          wr_req <= '0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_lane_fu.sv
// Directed bench for vector_lane_fu; granted writes are checked by a
// scoreboard monitor against expectations queued at dispatch time.
module tb_vector_lane_fu;
  import vector_lane_fu_pkg::*;

  localparam int unsigned W = VECTOR_REG_WIDTH;

  logic                        clk;
  logic                        reset;
  logic                        vld;
  logic [W-1:0]                data0;
  logic [W-1:0]                data1;
  logic [VREG_IDX_W-1:0]       vec_reg_in;
  logic [ADDR_FIELD_WIDTH-1:0] vec_addr;
  function_opcode_t            functional_opcode;
  logic                        busy;
  cntrl_req_t                  wr_req;
  logic                        wr_req_grant;
  logic                        illegal_op;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  cntrl_req_t  exp_q[$];

  vector_lane_fu dut (
    .clk               (clk),
    .reset             (reset),
    .vld               (vld),
    .data0             (data0),
    .data1             (data1),
    .vec_reg_in        (vec_reg_in),
    .vec_addr          (vec_addr),
    .functional_opcode (functional_opcode),
    .busy              (busy),
    .wr_req            (wr_req),
    .wr_req_grant      (wr_req_grant),
    .illegal_op        (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic cntrl_req_t mk_req(input v_register_t r, input logic [ADDR_FIELD_WIDTH-1:0] a,
                                        input logic [W-1:0] d);
    cntrl_req_t q;
    q.vld           = 1'b1;
    q.access_type   = WRITE_REQ;
    q.access_length = '0;
    q.stride_type   = NON_STRIDE;
    q.vec_reg_ptr   = r;
    q.addr          = a;
    q.data          = d;
    return q;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input function_opcode_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input v_register_t r, input logic [ADDR_FIELD_WIDTH-1:0] ad);
    vld = 1'b1; data0 = a; data1 = b; vec_reg_in = r; vec_addr = ad; functional_opcode = op;
  endtask

  // Sample busy and wr_req.vld mid-cycle, then advance one cycle.
  task automatic chk_cyc(input string n, input logic b, input logic w);
    @(negedge clk);
    check({n, "_busy"}, 64'(busy), 64'(b));
    check({n, "_wvld"}, 64'(wr_req.vld), 64'(w));
    step();
  endtask

  // Called in the cycle after acceptance with grant high; checks write latency.
  task automatic wait_write(input string n, input int unsigned exp_lat);
    int unsigned lat = 1;
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wr_req.vld) begin
        seen = 1'b1;
        break;
      end
      step();
      lat++;
    end
    check(n, 64'(seen ? lat : 0), 64'(exp_lat));
    step();
  endtask

  // Scoreboard monitor: every granted write must match the oldest expectation.
  initial begin
    cntrl_req_t e;
    forever begin
      @(negedge clk);
      if (reset && wr_req.vld && wr_req_grant) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got %h expected no write", wr_req);
        end else begin
          e = exp_q.pop_front();
          check("write", 64'(wr_req), 64'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; vld = 1'b0; data0 = '0; data1 = '0; vec_reg_in = '0; vec_addr = '0;
    functional_opcode = SADD; wr_req_grant = 1'b0;
    repeat (2) step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wr_req", 64'(wr_req), 64'd0);
    check("rst_illegal", 64'(illegal_op), 64'd0);
    reset = 1'b1;
    step();

    // SADD 5+7 with grant already high: busy T+1..T+2, write at T+2.
    wr_req_grant = 1'b1;
    drive(SADD, 32'd5, 32'd7, 5'd3, 8'd9);
    exp_q.push_back(mk_req(5'd3, 8'd9, 32'd12));
    chk_cyc("t1_T", 1'b0, 1'b0);
    vld = 1'b0;
    check("t1_illegal", 64'(illegal_op), 64'd0);
    chk_cyc("t1_T1", 1'b1, 1'b0);
    chk_cyc("t1_T2", 1'b1, 1'b1);
    chk_cyc("t1_T3", 1'b0, 1'b0);

    // SSUB wraps; SMUL keeps the low word and takes MUL_LATENCY cycles.
    drive(SSUB, 32'd3, 32'd5, 5'd1, 8'd2);
    exp_q.push_back(mk_req(5'd1, 8'd2, 32'hFFFF_FFFE));
    step(); vld = 1'b0;
    wait_write("t2_ssub_lat", 2);
    drive(SMUL, 32'hFFFF_FFFF, 32'd2, 5'd7, 8'd4);
    exp_q.push_back(mk_req(5'd7, 8'd4, 32'hFFFF_FFFE));
    step(); vld = 1'b0;
    wait_write("t2_smul_lat", 4);
    chk_cyc("t2_idle", 1'b0, 1'b0);

    // Grant withheld 10 cycles: request frozen, dispatches ignored.
    wr_req_grant = 1'b0;
    drive(SADD, 32'd100, 32'd23, 5'd5, 8'd6);
    exp_q.push_back(mk_req(5'd5, 8'd6, 32'd123));
    step(); vld = 1'b0;
    chk_cyc("t3_T1", 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      drive(SSUB, W'(k), 32'd1, 5'd9, 8'd9);
      vld = k[0];
      @(negedge clk);
      check("t3_busy", 64'(busy), 64'd1);
      check("t3_hold", 64'(wr_req), 64'(mk_req(5'd5, 8'd6, 32'd123)));
      step();
    end
    vld = 1'b0;
    wr_req_grant = 1'b1;
    chk_cyc("t3_grant", 1'b1, 1'b1);
    chk_cyc("t3_done", 1'b0, 1'b0);

    // SDIV: divider when compiled in, otherwise an unsupported opcode.
`ifdef LANE_DIV_EN
    drive(SDIV, 32'd100, 32'd7, 5'd2, 8'd10);
    exp_q.push_back(mk_req(5'd2, 8'd10, 32'd14));
    step(); vld = 1'b0;
    check("t4_div_illegal", 64'(illegal_op), 64'd0);
    wait_write("t4_div_lat", W + 1);
    drive(SDIV, 32'd1234, 32'd0, 5'd3, 8'd11);
    exp_q.push_back(mk_req(5'd3, 8'd11, 32'hFFFF_FFFF));
    step(); vld = 1'b0;
    check("t4_div0_illegal", 64'(illegal_op), 64'd0);
    wait_write("t4_div0_lat", W + 1);
`else
    drive(SDIV, 32'd100, 32'd7, 5'd2, 8'd10);
    exp_q.push_back(mk_req(5'd2, 8'd10, 32'd0));
    step(); vld = 1'b0;
    check("t4_sdiv_illegal", 64'(illegal_op), 64'd1);
    wait_write("t4_sdiv_lat", 2);
    check("t4_sdiv_pulse_end", 64'(illegal_op), 64'd0);
`endif
    drive(function_opcode_t'(3'd6), 32'd8, 32'd8, 5'd4, 8'd12);
    exp_q.push_back(mk_req(5'd4, 8'd12, 32'd0));
    step(); vld = 1'b0;
    check("t4_unk_illegal", 64'(illegal_op), 64'd1);
    wait_write("t4_unk_lat", 2);
    check("t4_unk_pulse_end", 64'(illegal_op), 64'd0);

    // Reset during SMUL EXEC: op discarded, no write afterwards.
    drive(SMUL, 32'd9, 32'd9, 5'd4, 8'd4);
    step(); vld = 1'b0;
    step();
    reset = 1'b0;
    #1;
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_wr_req", 64'(wr_req), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    for (int k = 0; k < 5; k++) chk_cyc("t5_after", 1'b0, 1'b0);

    // Grant and new vld together: dropped; re-dispatch next cycle accepted.
    drive(SADD, 32'd1, 32'd2, 5'd1, 8'd1);
    exp_q.push_back(mk_req(5'd1, 8'd1, 32'd3));
    step(); vld = 1'b0;
    step();
    drive(SADD, 32'd40, 32'd2, 5'd2, 8'd2);
    chk_cyc("t6_T2", 1'b1, 1'b1);
    exp_q.push_back(mk_req(5'd2, 8'd2, 32'd42));
    chk_cyc("t6_T3", 1'b0, 1'b0);
    vld = 1'b0;
    chk_cyc("t6_T4", 1'b1, 1'b0);
    chk_cyc("t6_T5", 1'b1, 1'b1);
    chk_cyc("t6_T6", 1'b0, 1'b0);

    repeat (3) step();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
